vector_bias_pipe: RTL and testbench

VECTOR_BIAS_PIPE -- requirements
Module: vector_bias_pipe

---
 rtl/vector_bias_pipe.sv | 174 +++++++++++++++++
 tb/tb_vector_bias_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_bias_pipe.sv
// vector_bias_pipe: LANES-wide floating-point x+/-bias, 2-stage valid/ready pipe.
// Optional ReLU on results: define VECTOR_BIAS_RELU_EN (adds port in_relu).
module vector_bias_pipe #(
   parameter int LANES = 16,
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     in_x    [LANES],
   input  logic [EXP_W+MAN_W:0]     in_bias [LANES],
   input  logic                     in_sub,
`ifdef VECTOR_BIAS_RELU_EN
   input  logic                     in_relu,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_data [LANES]
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int E    = MAN_W + 4;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam int S1W  = 5 + EXP_W + 2 * E;

   // S1 word: {nan, inf, inf_sign, sign, eff_sub, exp_big, sig_big, sig_small_aligned}
   function automatic logic [S1W-1:0] f_s1(
      input logic [W-1:0] x,
      input logic [W-1:0] b,
      input logic         sub
   );
      logic sx, sb, xz, bz, xi, bi, xn, bn, sw;
      logic [EXP_W-1:0] ex, eb, el, es, d;
      logic [MAN_W-1:0] mx, mb;
      logic [E-1:0] wx, wb, gl, gs, al;
      logic [2*E-1:0] wd;
      logic [31:0] dd;
      sx = x[W-1];
      sb = b[W-1] ^ sub;
      ex = x[W-2:MAN_W];
      eb = b[W-2:MAN_W];
      mx = x[MAN_W-1:0];
      mb = b[MAN_W-1:0];
      xz = (ex == '0);
      bz = (eb == '0);
      xi = (&ex) & ~(|mx);
      bi = (&eb) & ~(|mb);
      xn = (&ex) & (|mx);
      bn = (&eb) & (|mb);
      wx = xz ? '0 : {1'b1, mx, 3'b000};
      wb = bz ? '0 : {1'b1, mb, 3'b000};
      sw = {ex, mx & {MAN_W{~xz}}} < {eb, mb & {MAN_W{~bz}}};
      el = sw ? eb : ex;
      es = sw ? ex : eb;
      gl = sw ? wb : wx;
      gs = sw ? wx : wb;
      d  = el - es;
      dd = {{(32-EXP_W){1'b0}}, d};
      if (dd > E) dd = E;
      wd = {gs, {E{1'b0}}} >> dd;
      al = {wd[2*E-1:E+1], wd[E] | (|wd[E-1:0])};
      return {xn | bn | (xi & bi & (sx ^ sb)), xi | bi,
              xi ? sx : sb, sw ? sb : sx, sx ^ sb, el, gl, al};
   endfunction

   // Add/subtract aligned significands, normalise, round-to-nearest-even, pack.
   function automatic logic [W-1:0] f_s2(input logic [S1W-1:0] p);
      logic nan, inf, is, sg, su, up, fnd;
      logic [EXP_W-1:0] ep;
      logic [E-1:0] gl, gs, n;
      logic [E:0] sm;
      logic [MAN_W+1:0] m;
      logic [W-1:0] r;
      int e, lz;
      {nan, inf, is, sg, su, ep, gl, gs} = p;
      sm  = su ? {1'b0, gl - gs} : {1'b0, gl} + {1'b0, gs};
      e   = 0;
      e[EXP_W-1:0] = ep;
      lz  = 0;
      fnd = 1'b0;
      n   = '0;
      if (sm[E]) begin
         n = {sm[E:2], sm[1] | sm[0]};
         e = e + 1;
      end else begin
         for (int i = E - 1; i >= 0; i--) begin
            if (!fnd) begin
               if (sm[i]) fnd = 1'b1;
               else lz = lz + 1;
            end
         end
         n = sm[E-1:0] << lz;
         e = e - lz;
      end
      up = n[2] & (n[1] | n[0] | n[3]);
      m  = {1'b0, n[E-1:3]} + {{(MAN_W+1){1'b0}}, up};
      if (m[MAN_W+1]) e = e + 1;
      if (nan)
         r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (inf)
         r = {is, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (sm == '0)
         r = {sg & ~su, {(W-1){1'b0}}};
      else if (e <= 0)
         r = {sg, {(W-1){1'b0}}};
      else if (e >= EMAX)
         r = {sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         r = {sg, e[EXP_W-1:0], m[MAN_W-1:0]};
      return r;
   endfunction

   logic           r_s1_v, r_s2_v;
   logic [S1W-1:0] r_s1_p [LANES];
   logic [W-1:0]   r_s2_d [LANES];
   logic [S1W-1:0] w_s1_p [LANES];
   logic [W-1:0]   w_s2_d [LANES];
   logic           w_ld1, w_ld2;
`ifdef VECTOR_BIAS_RELU_EN
   logic           r_s1_relu;
`endif

   assign w_ld2     = ~r_s2_v | out_ready;
   assign w_ld1     = ~r_s1_v | w_ld2;
   assign in_ready  = reset & w_ld1;
   assign out_valid = r_s2_v;
   assign out_data  = r_s2_d;

   // Per-lane unpack/compare/align of the presented operands.
   always_comb begin
      for (int l = 0; l < LANES; l++)
         w_s1_p[l] = f_s1(in_x[l], in_bias[l], in_sub);
   end

   // Per-lane add/normalise/round of the S1 contents, then optional ReLU.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_s2_d[l] = f_s2(r_s1_p[l]);
`ifdef VECTOR_BIAS_RELU_EN
         if (r_s1_relu && !r_s1_p[l][S1W-1] && w_s2_d[l][W-1])
            w_s2_d[l] = '0;
`endif
      end
   end

   // Stage 1 register: loads when empty or when stage 2 advances.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_v <= 1'b0;
         for (int l = 0; l < LANES; l++) r_s1_p[l] <= '0;
`ifdef VECTOR_BIAS_RELU_EN
         r_s1_relu <= 1'b0;
`endif
      end else if (w_ld1) begin
         r_s1_v <= in_valid;
         r_s1_p <= w_s1_p;
`ifdef VECTOR_BIAS_RELU_EN
         r_s1_relu <= in_relu;
`endif
      end
   end

   // Stage 2 register: holds its result while downstream stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s2_v <= 1'b0;
         for (int l = 0; l < LANES; l++) r_s2_d[l] <= '0;
      end else if (w_ld2) begin
         r_s2_v <= r_s1_v;
         r_s2_d <= w_s2_d;
      end
   end
endmodule

// File: tb/tb_vector_bias_pipe.sv
// tb_vector_bias_pipe: randomized + directed bench for vector_bias_pipe (FP16).
// Define VECTOR_BIAS_RELU_EN to also exercise the ReLU option.
`timescale 1ns/1ps
module tb_vector_bias_pipe;
   localparam int L = 16;
   typedef logic [L-1:0][15:0] pvec_t;

   localparam logic [15:0] DX0 [6] = '{16'h4200, 16'h3C00, 16'h7C00, 16'h7BFF, 16'h0001, 16'h3C00};
   localparam logic [15:0] DB0 [6] = '{16'hC600, 16'h3C00, 16'h7C00, 16'h7BFF, 16'h8000, 16'h1000};
   localparam logic [15:0] DX1 [6] = '{16'h3200, 16'h3200, 16'h7BFF, 16'h8000, 16'h7C00, 16'h3C01};
   localparam logic [15:0] DB1 [6] = '{16'h4600, 16'h4600, 16'h7BFF, 16'h8000, 16'hFC00, 16'h1000};
   localparam logic        DSB [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [15:0] DE0 [6] = '{16'hC200, 16'h0000, 16'h7E00, 16'h7C00, 16'h0000, 16'h3C00};
   localparam logic [15:0] DE1 [6] = '{16'h4630, 16'hC5D0, 16'h0000, 16'h8000, 16'h7E00, 16'h3C02};

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, in_sub, out_valid, out_ready;
   logic [15:0] in_x [L];
   logic [15:0] in_bias [L];
   logic [15:0] out_data [L];
`ifdef VECTOR_BIAS_RELU_EN
   logic in_relu;
`endif
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vector_bias_pipe dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_bias(in_bias), .in_sub(in_sub),
`ifdef VECTOR_BIAS_RELU_EN
      .in_relu(in_relu),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   // Exact integer sum of the two values, then rounded back to FP16.
   function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] b, input logic sub);
      logic sx, sb, sg;
      int ex, eb, mx, mb, p, e, sh;
      longint vx, vb, s, a, rem, half, sig;
      sx = x[15]; sb = b[15] ^ sub;
      ex = int'(x[14:10]); eb = int'(b[14:10]);
      mx = int'(x[9:0]);   mb = int'(b[9:0]);
      if ((ex == 31 && mx != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
      if (ex == 31 && eb == 31) return (sx == sb) ? {sx, 15'h7C00} : 16'h7E00;
      if (ex == 31) return {sx, 15'h7C00};
      if (eb == 31) return {sb, 15'h7C00};
      vx = (ex == 0) ? 64'sd0 : (longint'(1024 + mx) <<< (ex - 1));
      vb = (eb == 0) ? 64'sd0 : (longint'(1024 + mb) <<< (eb - 1));
      if (sx) vx = -vx;
      if (sb) vb = -vb;
      s = vx + vb;
      if (s == 0) return (ex == 0 && eb == 0 && sx && sb) ? 16'h8000 : 16'h0000;
      sg = (s < 0);
      a = sg ? -s : s;
      p = 0;
      for (int i = 0; i < 63; i++) if (a[i]) p = i;
      e = p - 9;
      if (e < 1) return {sg, 15'h0000};
      sh = e - 1;
      sig = a >>> sh;
      if (sh > 0) begin
         rem  = a & ((64'sd1 <<< sh) - 1);
         half = 64'sd1 <<< (sh - 1);
         if (rem > half || (rem == half && sig[0])) sig = sig + 1;
      end
      if (sig == 2048) begin sig = 1024; e = e + 1; end
      if (e >= 31) return {sg, 15'h7C00};
      return {sg, e[4:0], sig[9:0]};
   endfunction

   function automatic pvec_t expect_vec();
      pvec_t v;
      logic [15:0] r;
      for (int l = 0; l < L; l++) begin
         r = ref_add(in_x[l], in_bias[l], in_sub);
`ifdef VECTOR_BIAS_RELU_EN
         if (in_relu && r[15] && !(r[14:10] == 5'h1F && r[9:0] != 10'h0)) r = 16'h0000;
`endif
         v[l] = r;
      end
      return v;
   endfunction

   function automatic pvec_t get_out();
      pvec_t v;
      for (int l = 0; l < L; l++) v[l] = out_data[l];
      return v;
   endfunction

   function automatic logic [15:0] rnd_fp();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 9))
         0: v[14:10] = 5'h1F;
         1: v[14:10] = 5'h00;
         2: v[14:10] = 5'h1E;
         default: ;
      endcase
      return v;
   endfunction

   task automatic fill_random();
      for (int l = 0; l < L; l++) begin
         in_x[l] = rnd_fp();
         if ($urandom_range(0, 3) == 0)
            in_bias[l] = in_x[l] ^ 16'h8000 ^ 16'($urandom_range(0, 15));
         else
            in_bias[l] = rnd_fp();
      end
      in_sub = 1'($urandom_range(0, 1));
`ifdef VECTOR_BIAS_RELU_EN
      in_relu = 1'($urandom_range(0, 1));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      fill_random();
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      checks++;
      if (get_out() !== '0) begin errors++; $display("FAIL rst_out_data got=%h want=0", get_out()); end
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_directed();
      pvec_t ev;
      pvec_t ov;
      for (int i = 0; i < 6; i++) begin
         fill_random();
         in_x[0] = DX0[i]; in_bias[0] = DB0[i];
         in_x[1] = DX1[i]; in_bias[1] = DB1[i];
         in_sub = DSB[i];
`ifdef VECTOR_BIAS_RELU_EN
         in_relu = 1'b0;
`endif
         in_valid = 1'b1;
         out_ready = 1'b1;
         ev = expect_vec();
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early got=%b want=0", i, out_valid); end
         tick();
         ov = get_out();
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
         checks++;
         if (ov[0] !== DE0[i]) begin errors++; $display("FAIL dir%0d_lane0 got=%h want=%h", i, ov[0], DE0[i]); end
         checks++;
         if (ov[1] !== DE1[i]) begin errors++; $display("FAIL dir%0d_lane1 got=%h want=%h", i, ov[1], DE1[i]); end
         checks++;
         if (ov !== ev) begin errors++; $display("FAIL dir%0d_vec got=%h want=%h", i, ov, ev); end
         tick();
      end
   endtask

   task automatic test_random();
      pvec_t q[$];
      pvec_t hold;
      logic stall;
      stall = 1'b0;
      hold = '0;
      for (int c = 0; c < 300; c++) begin
         fill_random();
         in_valid  = (c < 260) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || get_out() !== hold) begin
               errors++; $display("FAIL rnd_hold got=%b/%h want=1/%h", out_valid, get_out(), hold);
            end
         end
         checks++;
         if (in_ready !== !(q.size() == 2 && !out_ready)) begin
            errors++; $display("FAIL rnd_in_ready got=%b occ=%0d out_ready=%b", in_ready, q.size(), out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0 || get_out() !== q[0]) begin
               errors++; $display("FAIL rnd_data got=%h want=%h", get_out(), (q.size() != 0) ? q[0] : pvec_t'('x));
            end
            if (q.size() != 0) void'(q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(expect_vec());
         stall = out_valid && !out_ready;
         hold = get_out();
         tick();
      end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL rnd_drain left=%0d want=0", q.size()); end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      pvec_t q[$];
      pvec_t hold;
      logic stall;
      logic [3:0] pat;
      int n_in, n_out, c;
      pat = 4'b1001;
      stall = 1'b0;
      hold = '0;
      n_in = 0; n_out = 0; c = 0;
      fill_random();
      while (n_out < 8 && c < 100) begin
         in_valid  = (n_in < 8);
         out_ready = pat[c % 4];
         #1;
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || get_out() !== hold) begin
               errors++; $display("FAIL b2b_hold got=%b/%h want=1/%h", out_valid, get_out(), hold);
            end
         end
         checks++;
         if (in_ready !== !(q.size() == 2 && !out_ready)) begin
            errors++; $display("FAIL b2b_in_ready got=%b occ=%0d out_ready=%b", in_ready, q.size(), out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0 || get_out() !== q[0]) begin
               errors++; $display("FAIL b2b_data%0d got=%h want=%h", n_out, get_out(), (q.size() != 0) ? q[0] : pvec_t'('x));
            end
            if (q.size() != 0) void'(q.pop_front());
            n_out++;
         end
         stall = out_valid && !out_ready;
         hold = get_out();
         if (in_valid && in_ready) begin
            q.push_back(expect_vec());
            n_in++;
            tick();
            fill_random();
         end else begin
            tick();
         end
         c++;
      end
      in_valid = 1'b0;
      checks++;
      if (n_out != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", n_out); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      in_valid = 1'b1;
      fill_random();
      tick();
      fill_random();
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill got=%b want=1", out_valid); end
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
      checks++;
      if (get_out() !== '0) begin errors++; $display("FAIL mid_out_data got=%h want=0", get_out()); end
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got=%b want=1", in_ready); end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got=%b want=0", c, out_valid); end
      end
   endtask

`ifdef VECTOR_BIAS_RELU_EN
   task automatic test_relu();
      pvec_t ov;
      for (int i = 0; i < 2; i++) begin
         fill_random();
         in_x[0] = 16'h4200; in_bias[0] = 16'hC600; in_sub = 1'b0;
         in_relu = (i == 0);
         in_valid = 1'b1;
         out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         ov = get_out();
         checks++;
         if (out_valid !== 1'b1 || ov[0] !== ((i == 0) ? 16'h0000 : 16'hC200)) begin
            errors++; $display("FAIL relu%0d got=%b/%h want=1/%h", i, out_valid, ov[0], (i == 0) ? 16'h0000 : 16'hC200);
         end
         tick();
      end
   endtask
`endif

   initial begin
      reset = 1'b0;
      in_valid = 1'b0;
      in_sub = 1'b0;
      out_ready = 1'b0;
`ifdef VECTOR_BIAS_RELU_EN
      in_relu = 1'b0;
`endif
      for (int l = 0; l < L; l++) begin
         in_x[l] = '0;
         in_bias[l] = '0;
      end
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
`ifdef VECTOR_BIAS_RELU_EN
      test_relu();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
